// File: rtl/cl_note_reader_pkg.sv
// Shared definitions for the song metadata BRAM word format.
// Used by both the metadata loader and the playback-side note reader.
package cl_note_reader_pkg;

    // System codes in word[31:29].
    localparam logic [2:0] SYS_NOTE = 3'b000;
    localparam logic [2:0] SYS_END  = 3'b111;

    // Field bit positions within a 32-bit note word.
    localparam int unsigned SYS_MSB    = 31;
    localparam int unsigned SYS_LSB    = 29;
    localparam int unsigned PITCH_MSB  = 28;
    localparam int unsigned PITCH_LSB  = 23;
    localparam int unsigned STRING_MSB = 22;
    localparam int unsigned STRING_LSB = 20;
    localparam int unsigned FRET_MSB   = 19;
    localparam int unsigned FRET_LSB   = 16;
    localparam int unsigned TIME_MSB   = 15;
    localparam int unsigned TIME_LSB   = 0;

    typedef struct packed {
        logic [2:0]  sys;
        logic [5:0]  pitch;
        logic [2:0]  string_no;
        logic [3:0]  fret;
        logic [15:0] note_time;
    } note_word_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StDecode,
        StHold,
        StEmit,
        StDone
    } reader_state_t;

endpackage

// File: rtl/cl_note_reader_if.sv
// BRAM read port plus the note event valid/ready channel of the note reader.
interface cl_note_reader_if #(
    parameter int unsigned LOGSIZE = 12
);
    logic [LOGSIZE-1:0] rd_addr;
    logic [31:0]        rd_data;
    logic               note_valid;
    logic               note_ready;
    logic [5:0]         note_pitch;
    logic [2:0]         note_string;
    logic [3:0]         note_fret;
    logic [15:0]        note_time;

    // Reader side: drives the address and the note event.
    modport master (
        output rd_addr,
        input  rd_data,
        output note_valid,
        input  note_ready,
        output note_pitch,
        output note_string,
        output note_fret,
        output note_time
    );

    // Memory/consumer side.
    modport slave (
        input  rd_addr,
        output rd_data,
        input  note_valid,
        output note_ready,
        input  note_pitch,
        input  note_string,
        input  note_fret,
        input  note_time
    );
endinterface

// File: rtl/cl_song_timer.sv
// Song time in ms ticks: cleared on song start, frozen by pause, saturates at 16'hFFFF.
module cl_song_timer (
    input  logic        clk25,
    input  logic        reset,
    input  logic        clear,
    input  logic        run,
    input  logic        ms_tick,
    output logic [15:0] song_time
);

    // Count ms ticks while running; hold at the top value instead of wrapping.
    always_ff @(posedge clk25) begin
        if (reset || clear) begin
            song_time <= 16'd0;
        end else if (run && ms_tick && (song_time != 16'hFFFF)) begin
            song_time <= song_time + 16'd1;
        end
    end

endmodule

// File: rtl/cl_note_reader.sv
// Playback-side reader: walks the song metadata BRAM and releases each note
// as a valid/ready event once its time falls inside the lookahead window.
module cl_note_reader
    import cl_note_reader_pkg::*;
#(
    parameter int unsigned LOGSIZE     = 12,
    parameter int unsigned ADDR_STRIDE = 32,
    parameter logic [15:0] LEAD        = 16'd2000
) (
    input  logic             clk25,
    input  logic             reset,
    input  logic             start,
    input  logic             loaded,
    input  logic             pause,
    input  logic             ms_tick,
    cl_note_reader_if.master bus,
    output logic [15:0]      song_time,
    output logic             playing,
    output logic             done,
    output logic             overflow
);

    reader_state_t      state;
    logic [LOGSIZE-1:0] ptr_q;
    note_word_t         word_q;
    logic               valid_q;
    logic               playing_q;
    logic               done_q;
    logic               overflow_q;

    note_word_t         rd_word;
    logic [LOGSIZE:0]   ptr_sum;
    logic [LOGSIZE-1:0] ptr_next;
    logic               ptr_wrap;
    logic               start_ok;
    logic               due;

    assign rd_word  = note_word_t'(bus.rd_data);
    // Carry out of the pointer add means the walk ran off the end of the BRAM.
    assign ptr_sum  = {1'b0, ptr_q} + (LOGSIZE + 1)'(ADDR_STRIDE);
    assign ptr_next = ptr_sum[LOGSIZE-1:0];
    assign ptr_wrap = ptr_sum[LOGSIZE];
    assign start_ok = (state == StIdle) && start && loaded;
    // 17-bit compare so song_time + LEAD never wraps around.
    assign due      = (word_q.sys == SYS_NOTE) &&
                      ({1'b0, word_q.note_time} <= ({1'b0, song_time} + {1'b0, LEAD}));

    // Song time keeps running after DONE so the display tail can finish.
    cl_song_timer u_timer (
        .clk25    (clk25),
        .reset    (reset),
        .clear    (start_ok),
        .run      ((playing_q || done_q) && !pause),
        .ms_tick  (ms_tick),
        .song_time(song_time)
    );

    // Sequencer: owns state, pointer, latched word and all status flags.
    always_ff @(posedge clk25) begin
        if (reset) begin
            state      <= StIdle;
            ptr_q      <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_ok) begin
                        ptr_q     <= '0;
                        playing_q <= 1'b1;
                        state     <= StFetch;
                    end
                end
                StFetch:  state <= StWait;
                StWait:   state <= StDecode;
                StDecode: begin
                    word_q <= rd_word;
                    if (rd_word.sys == SYS_END) begin
                        playing_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= StDone;
                    end else if (rd_word.sys == SYS_NOTE) begin
                        state <= StHold;
                    end else begin
                        // Unknown system code: skip the word.
                        ptr_q <= ptr_next;
                        if (ptr_wrap) begin
                            overflow_q <= 1'b1;
                            done_q     <= 1'b1;
                            playing_q  <= 1'b0;
                            state      <= StDone;
                        end else begin
                            state <= StFetch;
                        end
                    end
                end
                StHold: begin
                    if (due) begin
                        valid_q <= 1'b1;
                        state   <= StEmit;
                    end
                end
                StEmit: begin
                    // Pause does not gate the handshake; fields stay put until it completes.
                    if (bus.note_ready) begin
                        valid_q <= 1'b0;
                        ptr_q   <= ptr_next;
                        if (ptr_wrap) begin
                            overflow_q <= 1'b1;
                            done_q     <= 1'b1;
                            playing_q  <= 1'b0;
                            state      <= StDone;
                        end else begin
                            state <= StFetch;
                        end
                    end
                end
                StDone:  state <= StDone;
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.rd_addr     = ptr_q;
    assign bus.note_valid  = valid_q;
    assign bus.note_pitch  = word_q[PITCH_MSB:PITCH_LSB];
    assign bus.note_string = word_q[STRING_MSB:STRING_LSB];
    assign bus.note_fret   = word_q[FRET_MSB:FRET_LSB];
    assign bus.note_time   = word_q[TIME_MSB:TIME_LSB];
    assign playing         = playing_q;
    assign done            = done_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_cl_note_reader.sv
// Directed bench for cl_note_reader: two instances (LEAD=0 and LEAD=150) share
// one behavioural BRAM and the same stimulus.
module tb_cl_note_reader;

    logic clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    logic        reset, start, loaded, pause, ms_tick, tick_en, note_ready;
    logic [15:0] song_time_a, song_time_b;
    logic        playing_a, playing_b, done_a, done_b, overflow_a, overflow_b;
    logic [31:0] mem [0:4095];
    int          checks   = 0;
    int          failures = 0;

    cl_note_reader_if #(.LOGSIZE(12)) bus_a ();
    cl_note_reader_if #(.LOGSIZE(12)) bus_b ();

    assign bus_a.note_ready = note_ready;
    assign bus_b.note_ready = note_ready;

    // Synchronous-read BRAM model: dout valid one cycle after the address.
    always @(posedge clk25) begin
        bus_a.rd_data <= mem[bus_a.rd_addr];
        bus_b.rd_data <= mem[bus_b.rd_addr];
    end

    cl_note_reader #(.LOGSIZE(12), .ADDR_STRIDE(32), .LEAD(16'd0)) dut_a (
        .clk25(clk25), .reset(reset), .start(start), .loaded(loaded), .pause(pause),
        .ms_tick(ms_tick), .bus(bus_a), .song_time(song_time_a), .playing(playing_a),
        .done(done_a), .overflow(overflow_a)
    );

    cl_note_reader #(.LOGSIZE(12), .ADDR_STRIDE(32), .LEAD(16'd150)) dut_b (
        .clk25(clk25), .reset(reset), .start(start), .loaded(loaded), .pause(pause),
        .ms_tick(ms_tick), .bus(bus_b), .song_time(song_time_b), .playing(playing_b),
        .done(done_b), .overflow(overflow_b)
    );

    typedef struct packed {
        logic [5:0]  pitch;
        logic [2:0]  str;
        logic [3:0]  fret;
        logic [15:0] ntime;
        logic [15:0] stime;
    } ev_t;

    typedef struct packed {
        logic [31:0] word;
        logic [5:0]  pitch;
        logic [2:0]  str;
        logic [3:0]  fret;
        logic [15:0] ntime;
        logic [15:0] st_a;
        logic [15:0] st_b;
    } vec_t;

    ev_t         ev_a[$];
    ev_t         ev_b[$];
    logic [11:0] addr_log[$];
    logic [11:0] last_addr = 12'd0;
    int          tick_cnt;

    // Free-running ms strobe, one pulse every 4 cycles while enabled.
    initial begin
        ms_tick  = 1'b0;
        tick_cnt = 0;
        forever begin
            @(posedge clk25);
            #1;
            if (tick_en) begin
                tick_cnt++;
                ms_tick = (tick_cnt % 4 == 0);
            end else begin
                tick_cnt = 0;
                ms_tick  = 1'b0;
            end
        end
    end

    // Capture transfers and rd_addr changes on the falling edge.
    always @(negedge clk25) begin
        if (bus_a.note_valid && bus_a.note_ready)
            ev_a.push_back({bus_a.note_pitch, bus_a.note_string, bus_a.note_fret,
                            bus_a.note_time, song_time_a});
        if (bus_b.note_valid && bus_b.note_ready)
            ev_b.push_back({bus_b.note_pitch, bus_b.note_string, bus_b.note_fret,
                            bus_b.note_time, song_time_b});
        if (bus_a.rd_addr != last_addr) begin
            addr_log.push_back(bus_a.rd_addr);
            last_addr = bus_a.rd_addr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ev(input string tag, input ev_t got, input logic [5:0] p,
                            input logic [2:0] s, input logic [3:0] f,
                            input logic [15:0] t, input logic [15:0] st);
        chk({tag, "_pitch"}, got.pitch, p);
        chk({tag, "_string"}, got.str, s);
        chk({tag, "_fret"}, got.fret, f);
        chk({tag, "_time"}, got.ntime, t);
        chk({tag, "_song_time"}, got.stime, st);
    endtask

    task automatic step();
        @(posedge clk25);
        #5;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        start      = 1'b0;
        pause      = 1'b0;
        tick_en    = 1'b0;
        note_ready = 1'b1;
        loaded     = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        ev_a.delete();
        ev_b.delete();
        addr_log.delete();
    endtask

    task automatic wait_valid_a(input int budget, output int n);
        n = 0;
        while (!bus_a.note_valid && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done_a(input int budget, output int n);
        n = 0;
        while (!done_a && n < budget) begin
            step();
            n++;
        end
    endtask

    vec_t        vecs[2];
    int          n;
    int          seen;
    logic [15:0] exp_st;
    logic [15:0] st0;

    initial begin
        vecs[0] = '{32'h14250064, 6'd40, 3'd2, 4'd5, 16'd100, 16'd100, 16'd0};
        vecs[1] = '{32'h0C3100C8, 6'd24, 3'd3, 4'd1, 16'd200, 16'd200, 16'd50};

        // Reset state.
        do_reset();
        chk("rst_valid", bus_a.note_valid, 1'b0);
        chk("rst_rd_addr", bus_a.rd_addr, 12'd0);
        chk("rst_song_time", song_time_a, 16'd0);
        chk("rst_playing", playing_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_overflow", overflow_a, 1'b0);
        chk("rst_fields", {bus_a.note_pitch, bus_a.note_string, bus_a.note_fret,
                           bus_a.note_time}, 29'd0);

        // start with loaded low is ignored.
        loaded = 1'b0;
        pulse_start();
        step();
        step();
        chk("noload_playing", playing_a, 1'b0);
        loaded = 1'b1;

        // Two timed notes plus end marker; LEAD=0 on A, LEAD=150 on B.
        for (int i = 0; i < 2; i++) mem[32 * i] = vecs[i].word;
        mem[64] = 32'hE0000000;
        pulse_start();
        chk("t1_fetch_addr", bus_a.rd_addr, 12'd0);
        chk("t1_playing", playing_a, 1'b1);
        repeat (6) step();
        tick_en = 1'b1;
        repeat (100) step();
        pulse_start();  // must be ignored mid-song
        wait_done_a(3000, n);
        chk("t1_done", done_a, 1'b1);
        chk("t1_count_a", ev_a.size(), 2);
        chk("t1_count_b", ev_b.size(), 2);
        for (int i = 0; i < 2; i++) begin
            check_ev($sformatf("t1_a%0d", i), ev_a[i], vecs[i].pitch, vecs[i].str,
                     vecs[i].fret, vecs[i].ntime, vecs[i].st_a);
            check_ev($sformatf("t1_b%0d", i), ev_b[i], vecs[i].pitch, vecs[i].str,
                     vecs[i].fret, vecs[i].ntime, vecs[i].st_b);
        end
        chk("t1_addr_changes", addr_log.size(), 2);
        chk("t1_addr_1", addr_log[0], 12'd32);
        chk("t1_addr_2", addr_log[1], 12'd64);
        chk("t1_overflow", overflow_a, 1'b0);
        chk("t1_playing_done", playing_a, 1'b0);
        chk("t1_valid_done", bus_a.note_valid, 1'b0);
        chk("t1_done_b", done_b, 1'b1);
        st0 = song_time_a;
        repeat (20) step();
        chk("t1_time_runs_in_done", song_time_a > st0, 1'b1);

        // Backpressure: fields and pointer hold while ready is low.
        do_reset();
        mem[0]  = 32'h14250000;
        mem[32] = 32'h0C310000;
        mem[64] = 32'hE0000000;
        note_ready = 1'b0;
        pulse_start();
        wait_valid_a(20, n);
        chk("bp_emit_latency", n, 4);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold_fields%0d", i), {bus_a.note_valid, bus_a.note_pitch,
                bus_a.note_string, bus_a.note_fret, bus_a.note_time},
                {1'b1, 6'd40, 3'd2, 4'd5, 16'd0});
            chk($sformatf("bp_hold_addr%0d", i), bus_a.rd_addr, 12'd0);
            step();
        end
        chk("bp_no_transfer", ev_a.size(), 0);
        note_ready = 1'b1;
        step();
        note_ready = 1'b0;
        step();
        step();
        chk("bp_one_transfer", ev_a.size(), 1);
        wait_valid_a(20, n);
        chk("bp_second_valid", bus_a.note_valid, 1'b1);
        chk("bp_second_fields", {bus_a.note_pitch, bus_a.note_string, bus_a.note_fret,
                                 bus_a.note_time}, {6'd24, 3'd3, 4'd1, 16'd0});
        chk("bp_second_addr", bus_a.rd_addr, 12'd32);
        chk("bp_still_one", ev_a.size(), 1);
        note_ready = 1'b1;
        wait_done_a(50, n);
        chk("bp_done", done_a, 1'b1);
        chk("bp_total", ev_a.size(), 2);

        // Unknown system code is skipped.
        do_reset();
        mem[0]  = 32'h40000000;
        mem[32] = 32'h14250000;
        mem[64] = 32'hE0000000;
        pulse_start();
        wait_done_a(60, n);
        chk("skip_done", done_a, 1'b1);
        chk("skip_count", ev_a.size(), 1);
        check_ev("skip_ev", ev_a[0], 6'd40, 3'd2, 4'd5, 16'd0, 16'd0);

        // No end marker: 128 notes, then wrap.
        do_reset();
        for (int i = 0; i < 128; i++) mem[32 * i] = 32'h14250000;
        pulse_start();
        chk("ovf_not_early", overflow_a, 1'b0);
        wait_done_a(2000, n);
        chk("ovf_done", done_a, 1'b1);
        chk("ovf_flag", overflow_a, 1'b1);
        chk("ovf_count_a", ev_a.size(), 128);
        chk("ovf_count_b", ev_b.size(), 128);
        chk("ovf_playing", playing_a, 1'b0);
        chk("ovf_addr", bus_a.rd_addr, 12'd0);

        // Pause freezes song_time; model counts only unpaused ticks.
        do_reset();
        mem[0]  = 32'h1425FFFF;
        mem[32] = 32'hE0000000;
        pulse_start();
        tick_en = 1'b1;
        exp_st  = 16'd0;
        for (int i = 0; i < 40; i++) begin
            if (ms_tick && !pause) exp_st++;
            step();
        end
        chk("pause_before", song_time_a, exp_st);
        pause = 1'b1;
        seen  = 0;
        n     = 0;
        while (seen < 50 && n < 1000) begin
            if (ms_tick) seen++;
            step();
            n++;
        end
        chk("pause_ticks_seen", seen, 50);
        chk("pause_frozen", song_time_a, exp_st);
        chk("pause_playing", playing_a, 1'b1);
        pause = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ms_tick && !pause) exp_st++;
            step();
        end
        chk("pause_resume", song_time_a, exp_st);

        // Reset while a note is pending in EMIT.
        do_reset();
        mem[0]  = 32'h14250000;
        mem[32] = 32'hE0000000;
        note_ready = 1'b0;
        tick_en    = 1'b1;
        pulse_start();
        wait_valid_a(20, n);
        chk("rsemit_valid", bus_a.note_valid, 1'b1);
        repeat (8) step();
        reset = 1'b1;
        step();
        chk("rsemit_valid_low", bus_a.note_valid, 1'b0);
        chk("rsemit_song_time", song_time_a, 16'd0);
        chk("rsemit_playing", playing_a, 1'b0);
        chk("rsemit_addr", bus_a.rd_addr, 12'd0);
        reset   = 1'b0;
        tick_en = 1'b0;
        step();
        chk("rsemit_no_transfer", ev_a.size(), 0);
        note_ready = 1'b1;
        pulse_start();
        wait_done_a(60, n);
        chk("rsemit_restart_done", done_a, 1'b1);
        chk("rsemit_restart_count", ev_a.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cl_note_reader.md
Name: cl_note_reader

Overview:
- Playback-side reader for the song metadata BRAM. The metadata loader fills this BRAM with 32-bit note words; this block walks the same memory, addresses and word format included.
- Tracks song time in ms ticks and releases each note as a valid/ready event once the note's time comes within a lookahead window.
- Feeds the note-highway renderer and scoring logic. Runs on the 25 MHz domain alongside the BRAM read port.

Parameters:
- LOGSIZE, 12, BRAM address width.
- ADDR_STRIDE, 32, address increment per word; matches the loader's layout.
- LEAD, 16'd2000, lookahead in ms ticks; a note is released when note_time <= song_time + LEAD.

Ports:
- clk25  in  1  25 MHz clock; the only clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; accepted only in IDLE and only while loaded=1.
- loaded  in  1  metadata load complete.
- pause  in  1  freezes song_time while high.
- ms_tick  in  1  one-cycle strobe, once per ms.
- rd_addr  out  LOGSIZE  BRAM read address, registered.
- rd_data  in  32  BRAM dout, valid 1 cycle after rd_addr changes.
- note_valid  out  1  note event available.
- note_ready  in  1  consumer accepts the event.
- note_pitch  out  6  word[28:23].
- note_string  out  3  word[22:20].
- note_fret  out  4  word[19:16].
- note_time  out  16  word[15:0].
- song_time  out  16  current song time.
- playing  out  1  high from ACTIVE entry until DONE.
- done  out  1  end marker reached; sticky until reset.
- overflow  out  1  address wrapped before an end marker; sticky.

Behaviour:
- Word format: [31:29] system code, where 000 = note and 111 = end; [28:23] pitch; [22:20] string; [19:16] fret; [15:0] time.
- Reset: all outputs 0, rd_addr=0, song_time=0, state IDLE. Reset mid-operation aborts any pending event immediately; note_valid drops the next cycle.
- States: IDLE -> FETCH -> WAIT -> DECODE -> {HOLD, FETCH, DONE}; HOLD -> EMIT -> FETCH.
- IDLE: on start & loaded, go to FETCH with rd_addr=0 and song_time=0. start while loaded=0 is ignored.
- FETCH: rd_addr holds the current pointer for one cycle.
- WAIT: one-cycle BRAM latency.
- DECODE: latch rd_data into the word register.
  - Code 111: go to DONE.
  - Code 000: go to HOLD.
  - Any other code: skip. Pointer += ADDR_STRIDE, go to FETCH.
- HOLD: compare in 17 bits, {1'b0,note_time} <= {1'b0,song_time} + LEAD (no wrap). When true, go to EMIT.
- EMIT: note_valid=1 with fields stable.
  - On note_valid & note_ready: note_valid=0 next cycle, pointer += ADDR_STRIDE, go to FETCH.
  - Fields must not change while note_valid=1 and note_ready=0.
- Per-word overhead is 3 cycles minimum (FETCH, WAIT, DECODE). A note that is already due reaches EMIT 4 cycles after its FETCH.
- Pointer wrap: pointer is LOGSIZE bits, modulo 2^LOGSIZE. If an increment wraps to 0 without an end marker, set overflow=1 and done=1, go to DONE.
- song_time:
  - Increments on ms_tick while playing & !pause.
  - Saturates at 16'hFFFF.
  - Continues counting in DONE until reset, so the display tail can finish.
- Simultaneous events:
  - An ms_tick in the same cycle as the HOLD compare does not count toward that compare; it is used on the next cycle.
  - start outside IDLE is ignored.
  - pause during EMIT does not block the handshake.
- DONE: playing=0, done=1, note_valid=0. Exit only via reset.
- Notes must be time-ordered. Out-of-order notes are emitted immediately in memory order, with no reordering.

Decomposition:
- Shared package holds:
  - constants SYS_NOTE=3'b000 and SYS_END=3'b111;
  - field bit positions for pitch, string, fret and time;
  - a note-word struct typedef.
- Share the package with the metadata loader.
- One natural sub-module, cl_song_timer: ms_tick counter with pause and saturation.

Test Plan:
- Word addresses 0, 32, 64 hold 0x14250064 (pitch 40, string 2, fret 5, time 100), 0x0C3100C8 (pitch 24, string 3, fret 1, time 200), 0xE0000000; LEAD=0; note_ready tied 1; start -> event 1 at song_time=100 with 40/2/5, event 2 at song_time=200 with 24/3/1, then done=1 and rd_addr sequence 0, 32, 64.
- Same memory, LEAD=150 -> event 1 released at song_time=0, event 2 at song_time=50.
- Backpressure: note_ready=0 for 10 cycles while note_valid=1 -> fields stable and pointer unchanged; one cycle of ready -> exactly one transfer.
- Word 0x40000000 (code 010) at address 0, followed by a note -> the 010 word is skipped with no event, and the note is emitted.
- No end marker and all 128 strided slots hold notes with time 0 -> 128 events, then overflow=1 and done=1.
- pause held for 50 ms_ticks -> song_time frozen. Reset asserted during EMIT -> note_valid=0, song_time=0 and state IDLE on the next cycle.
